// File: rtl/mem_arb_4_3_pkg.sv
// Shared widths, FSM state encodings and request payload for the mem_4_3 arbiter.
package mem_arb_4_3_pkg;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 3;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_EN    = 3'd4,
    R_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arb_4_3_rr_arb_2.sv
// 2-way round-robin picker; MEM_ARB_FIXED_PRIO_EN makes requester 0 always win a tie.
module rr_arb_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign gnt_id            = ~req[0];
`else
  // On a tie the port that did not win last time goes next.
  assign gnt_id = (&req) ? ~last_grant : req[1];
`endif

endmodule

// File: rtl/mem_arb_4_3.sv
// Two-port arbiter/sequencer driving the mem_4_3 latch memory with setup/pulse/hold timing.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_arb_4_3
  import mem_arb_4_3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_cs,
  output logic              mem_rd,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] mem_o
);

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q;
  logic   load_c;
  logic   gnt_valid, gnt_id;
  req_t   sel_req;

  rr_arb_2 u_arb (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Payload of whichever requester the picker selected.
  always_comb begin
    sel_req.we    = we0;
    sel_req.addr  = addr0;
    sel_req.wdata = wdata0;
    if (gnt_id) begin
      sel_req.we    = we1;
      sel_req.addr  = addr1;
      sel_req.wdata = wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    load_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          load_c  = 1'b1;
          owner_d = gnt_id;
          state_d = sel_req.we ? W_SETUP : R_EN;
        end
      end
      W_SETUP: state_d = W_PULSE;
      W_PULSE: state_d = W_HOLD;
      W_HOLD:  state_d = IDLE;
      R_EN:    state_d = R_DONE;
      R_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are flops decoded from the next state, so they track the state register glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cs <= 1'b0;
      mem_rd <= 1'b1;
      mem_oe <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
    end else begin
      mem_cs <= (state_d == W_PULSE) || (state_d == R_EN);
      mem_rd <= (state_d != W_PULSE);
      mem_oe <= (state_d == R_EN);
      ack0   <= ((state_d == W_HOLD) || (state_d == R_DONE)) && !owner_d;
      ack1   <= ((state_d == W_HOLD) || (state_d == R_DONE)) && owner_d;
    end
  end

  // Address/data only move when an operation is launched from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a        <= '0;
      mem_i        <= '0;
      last_grant_q <= 1'b1;
    end else if (load_c) begin
      mem_a        <= sel_req.addr;
      mem_i        <= sel_req.wdata;
      last_grant_q <= gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state_q == R_EN) begin
      if (owner_q) rdata1 <= mem_o;
      else         rdata0 <= mem_o;
    end
  end

endmodule
